// File: rtl/sad_pkg.sv
// Shared types and constants for the SAD minimum tracker.
// Lane/row widths and FSM state encoding.
package sad_pkg;

  localparam int K_W   = 10;
  localparam int ROW_W = 12;

  localparam logic [63:0] SAD_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_e;

endpackage

// File: rtl/sad_row_adder.sv
// Sums four 10-bit partial SADs of one window row.
// Result is zero-extended to 12 bits and cannot overflow.
module sad_row_adder
  import sad_pkg::*;
(
  input  logic [K_W-1:0]   k1,
  input  logic [K_W-1:0]   k2,
  input  logic [K_W-1:0]   k3,
  input  logic [K_W-1:0]   k4,
  output logic [ROW_W-1:0] sum
);

  assign sum = ROW_W'(k1) + ROW_W'(k2)
             + ROW_W'(k3) + ROW_W'(k4);

endmodule

// File: rtl/sad_min_tracker.sv
// Accumulates window SADs for two candidates per pair and
// tracks the minimum SAD and its coordinates over a search.
module sad_min_tracker
  import sad_pkg::*;
#(
  parameter int WIN_ROWS = 16,
  parameter int COORD_W  = 8,
  parameter int ACC_W    = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               search_start,
  input  logic               search_end,
  input  logic               row_valid,
  input  logic [K_W-1:0]     KA1,
  input  logic [K_W-1:0]     KA2,
  input  logic [K_W-1:0]     KA3,
  input  logic [K_W-1:0]     KA4,
  input  logic [K_W-1:0]     KB1,
  input  logic [K_W-1:0]     KB2,
  input  logic [K_W-1:0]     KB3,
  input  logic [K_W-1:0]     KB4,
  input  logic [COORD_W-1:0] cand_x_a,
  input  logic [COORD_W-1:0] cand_x_b,
  input  logic [COORD_W-1:0] cand_y,
  output logic               busy,
  output logic               done,
  output logic [ACC_W-1:0]   best_sad,
  output logic [COORD_W-1:0] best_x,
  output logic [COORD_W-1:0] best_y,
  output logic               partial_drop
);

  localparam int CNT_W = $clog2(WIN_ROWS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIN_ROWS - 1);
  localparam logic [ACC_W-1:0] MAX  = ACC_W'(SAD_MAX);

  state_e state_q, state_d;

  logic [ROW_W-1:0]   row_a, row_b;
  logic [CNT_W-1:0]   row_cnt, cnt_nxt, cnt_after;
  logic [ACC_W-1:0]   acc_a, acc_b, sum_a, sum_b;
  logic [COORD_W-1:0] lat_xa, lat_xb, lat_y;
  logic [ACC_W-1:0]   cmp_a, cmp_b;
  logic [COORD_W-1:0] cmp_xa, cmp_xb, cmp_y;
  logic               cmp_pending;
  logic               take, first, last, a_wins;
  logic [ACC_W-1:0]   win_sad;
  logic [COORD_W-1:0] win_x;

  sad_row_adder u_add_a (
    .k1 (KA1),
    .k2 (KA2),
    .k3 (KA3),
    .k4 (KA4),
    .sum(row_a)
  );

  sad_row_adder u_add_b (
    .k1 (KB1),
    .k2 (KB2),
    .k3 (KB3),
    .k4 (KB4),
    .sum(row_b)
  );

  assign take  = row_valid && (state_q == RUN);
  assign first = (row_cnt == '0);
  assign last  = (row_cnt == LAST);

  assign sum_a = first ? ACC_W'(row_a)
                       : acc_a + ACC_W'(row_a);
  assign sum_b = first ? ACC_W'(row_b)
                       : acc_b + ACC_W'(row_b);

  assign cnt_nxt   = last ? '0 : row_cnt + 1'b1;
  assign cnt_after = take ? cnt_nxt : row_cnt;

  // A wins ties so the lower-x candidate of a pair is preferred
  assign a_wins  = (cmp_a <= cmp_b);
  assign win_sad = a_wins ? cmp_a : cmp_b;
  assign win_x   = a_wins ? cmp_xa : cmp_xb;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: ;
      RUN: begin
        busy = 1'b1;
        if (search_end) state_d = FLUSH;
      end
      FLUSH: begin
        busy = 1'b1;
        if (!cmp_pending) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (search_start) state_d = RUN;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      best_sad     <= MAX;
      best_x       <= '0;
      best_y       <= '0;
      row_cnt      <= '0;
      acc_a        <= '0;
      acc_b        <= '0;
      lat_xa       <= '0;
      lat_xb       <= '0;
      lat_y        <= '0;
      cmp_a        <= '0;
      cmp_b        <= '0;
      cmp_xa       <= '0;
      cmp_xb       <= '0;
      cmp_y        <= '0;
      cmp_pending  <= 1'b0;
      partial_drop <= 1'b0;
    end else if (search_start) begin
      best_sad     <= MAX;
      best_x       <= '0;
      best_y       <= '0;
      row_cnt      <= '0;
      acc_a        <= '0;
      acc_b        <= '0;
      cmp_pending  <= 1'b0;
      partial_drop <= 1'b0;
    end else begin
      if (cmp_pending) begin
        cmp_pending <= 1'b0;
        if (win_sad < best_sad) begin
          best_sad <= win_sad;
          best_x   <= win_x;
          best_y   <= cmp_y;
        end
      end
      if (take) begin
        acc_a   <= sum_a;
        acc_b   <= sum_b;
        row_cnt <= cnt_nxt;
        if (first) begin
          lat_xa <= cand_x_a;
          lat_xb <= cand_x_b;
          lat_y  <= cand_y;
        end
        if (last) begin
          cmp_a       <= sum_a;
          cmp_b       <= sum_b;
          cmp_xa      <= lat_xa;
          cmp_xb      <= lat_xb;
          cmp_y       <= lat_y;
          cmp_pending <= 1'b1;
        end
      end
      if (state_q == RUN && search_end && cnt_after != '0) begin
        partial_drop <= 1'b1;
        row_cnt      <= '0;
      end
    end
  end

endmodule

// File: doc/sad_min_tracker.md
Name: sad_min_tracker

Overview:
- Consumes the eight 10-bit partial SADs (KA1..KA4, KB1..KB4) from SADUnit, one window row per valid cycle.
- Accumulates full-window SADs for two candidate positions (A, B) evaluated in parallel.
- Tracks the running minimum SAD and its (x, y) over a whole search, and reports the result with a done pulse.
- Sits between SADUnit and the register file / writeback path that returns the best-match coordinates.

Parameters:
- WIN_ROWS, 16, rows per window (candidate complete after this many valid rows); power of two, >=2
- COORD_W, 8, width of candidate x/y coordinates
- ACC_W, 16, accumulator width; must be >= 12 + log2(WIN_ROWS)

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- search_start  in  1  pulse: clear minimum, begin new search
- search_end  in  1  pulse: no more rows this search
- row_valid  in  1  KA*/KB* hold one valid row this cycle
- KA1, KA2, KA3, KA4  in  10 each  candidate A partial SADs
- KB1, KB2, KB3, KB4  in  10 each  candidate B partial SADs
- cand_x_a, cand_x_b, cand_y  in  COORD_W each  candidate coordinates; sampled on the first row of a pair
- busy  out  1  search in progress
- done  out  1  one-cycle pulse: result valid
- best_sad  out  ACC_W  minimum SAD of the search
- best_x, best_y  out  COORD_W each  coordinates of the minimum
- partial_drop  out  1  sticky until next search_start: a partially accumulated pair was discarded at search_end

Behaviour:
- Reset (Reset=0, asynchronous) drives the following values:
  - state=IDLE, busy=0, done=0, partial_drop=0
  - best_sad=all ones, best_x=0, best_y=0
  - row_cnt=0, accumulators=0, cmp_pending=0
- FSM states: IDLE, RUN, FLUSH, DONE.
- Transitions:
  - IDLE -> RUN on search_start.
  - RUN -> FLUSH on search_end.
  - FLUSH -> DONE once cmp_pending=0 (immediately if nothing is pending).
  - DONE -> IDLE after one cycle.
- search_start in any state:
  - Restarts the search: best_sad=all ones, row_cnt=0, accumulators=0, cmp_pending=0, partial_drop=0; state=RUN next cycle.
  - This overrides search_end and row_valid in the same cycle.
- row_valid handling:
  - Honoured only in RUN; ignored in IDLE, FLUSH and DONE.
  - Row sums are zero-extended: rowA=KA1+KA2+KA3+KA4 and rowB=KB1+KB2+KB3+KB4, 12 bits, no overflow possible.
- When row_cnt==0 with row_valid:
  - Latch cand_x_a, cand_x_b and cand_y.
  - accA=rowA, accB=rowB.
- Otherwise with row_valid: accA+=rowA, accB+=rowB.
- On the row with row_cnt==WIN_ROWS-1:
  - Completed sums and coordinates move to the compare registers; cmp_pending=1; row_cnt wraps to 0.
  - Back-to-back rows are allowed; the next pair may start the following cycle with no stall.
- Compare stage (cycle after cmp_pending is set):
  - win = A if accA_c <= accB_c, else B (A wins ties).
  - If win_sad < best_sad (strictly less), update best_sad and best_x/best_y; earlier candidates win ties.
  - Clear cmp_pending.
- search_end in RUN:
  - A pair completing on that same cycle is still compared.
  - If row_cnt != 0 after that cycle's update, the partial pair is discarded and partial_drop=1.
- Output timing:
  - done=1 only in DONE: best_* valid in that cycle and held until the next search_start or reset.
  - Latency from the last-row cycle to done: 3 cycles when search_end coincides with the last row.
  - busy=1 in RUN and FLUSH.
- If a search ends with no completed pair: best_sad stays all ones and best_x/best_y stay 0.

Decomposition:
- Shared package sad_pkg holds:
  - FSM state typedef (IDLE/RUN/FLUSH/DONE)
  - K_W=10, ROW_W=12 constants
  - SAD_MAX constant (all ones)
- One natural sub-module: sad_row_adder (4x10-bit -> 12-bit sum), instantiated for A and B.

Test Plan:
- Reset mid-RUN with row_cnt=5 -> busy=0, best_sad=16'hFFFF, next search starts at row_cnt=0.
- WIN_ROWS=16, all KA*=10, all KB*=20, cand_x_a=3, cand_x_b=4, cand_y=7, search_end on last row -> done 3 cycles later; best_sad=640, best=(3,7).
- Two back-to-back pairs (32 consecutive row_valid): pair1 A=800/B=900, pair2 A=700/B=700 at x=(9,10), y=2 -> best_sad=700, best_x=9 (A wins tie).
- Pair1 min=500, pair2 min=500 -> best stays at pair1 coordinates (strict less-than).
- 16 full rows then 5 rows, then search_end -> partial_drop=1; best reflects only the first pair.
- search_start during FLUSH with cmp_pending=1 -> pending compare dropped, best_sad=16'hFFFF, no done pulse, state=RUN.
